// File: rtl/acia_bus_sequencer_if.sv
// CPU-side register bus of a 6850-style ACIA plus the client ports of the
// sequencer that owns it (two TX requesters, RX stream, config, init status).
interface acia_bus_sequencer_if;
  logic       acia_e;
  logic       acia_sel;
  logic       acia_rs;
  logic       acia_rw;
  logic [7:0] acia_din;
  logic [7:0] acia_dout;
  logic       tx0_valid;
  logic [7:0] tx0_data;
  logic       tx0_ready;
  logic       tx1_valid;
  logic [7:0] tx1_data;
  logic       tx1_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       cfg_req;
  logic [7:0] cfg_data;
  logic       cfg_ack;
  logic       busy_init;

  modport master (
    output acia_e, acia_sel, acia_rs, acia_rw, acia_din,
    input  acia_dout,
    input  tx0_valid, tx0_data, tx1_valid, tx1_data,
    output tx0_ready, tx1_ready,
    output rx_valid, rx_data, rx_err,
    input  cfg_req, cfg_data,
    output cfg_ack, busy_init
  );

  modport slave (
    input  acia_e, acia_sel, acia_rs, acia_rw, acia_din,
    output acia_dout,
    output tx0_valid, tx0_data, tx1_valid, tx1_data,
    input  tx0_ready, tx1_ready,
    input  rx_valid, rx_data, rx_err,
    output cfg_req, cfg_data,
    input  cfg_ack, busy_init
  );
endinterface

// File: rtl/acia_bus_sequencer.sv
// Bus master for a 6850-style ACIA: init, continuous status polling, RX drain,
// round-robin TX sharing between two requesters and run-time CR writes.
module acia_bus_sequencer #(
  parameter int         E_DIV      = 32,
  parameter logic [7:0] CR_INIT    = 8'h16,
  parameter logic [7:0] WR_HOLDOFF = 8'd64
) (
  input logic                  clk,
  input logic                  reset,
  acia_bus_sequencer_if.master bus
);
  localparam int PW = $clog2(E_DIV);

  typedef enum logic [2:0] {INIT_MR, INIT_CR, POLL, RD_DATA, WR_CR, WR_DATA} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [7:0]    hold_q, hold_d;
  logic          rr_q, rr_d;
  logic [7:0]    stat_q, stat_d;
  logic          sel_q, sel_d, rs_q, rs_d, rw_q, rw_d;
  logic [7:0]    din_q, din_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [1:0]    rx_err_q, rx_err_d;
  logic          cfg_ack_q, cfg_ack_d;
  logic          busy_q, busy_d;
  logic          wrote_q, wrote_d;

  logic cyc_start, cyc_end, any_v, gnt, grant_now;

  assign cyc_start = (ph_q == '0);
  assign cyc_end   = (ph_q == PW'(E_DIV - 1));
  assign any_v     = bus.tx0_valid | bus.tx1_valid;
  // Both valid: rr decides; otherwise whichever one is valid.
  assign gnt       = (bus.tx0_valid & bus.tx1_valid) ? rr_q : bus.tx1_valid;
  assign grant_now = (state_q == WR_DATA) && cyc_start && any_v;

  assign bus.acia_e    = (ph_q >= PW'(E_DIV / 2));
  assign bus.acia_sel  = sel_q;
  assign bus.acia_rs   = rs_q;
  assign bus.acia_rw   = rw_q;
  assign bus.acia_din  = din_q;
  assign bus.tx0_ready = grant_now & ~gnt;
  assign bus.tx1_ready = grant_now & gnt;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_err    = rx_err_q;
  assign bus.cfg_ack   = cfg_ack_q;
  assign bus.busy_init = busy_q;

  always_comb begin
    state_d    = state_q;
    ph_d       = cyc_end ? '0 : ph_q + PW'(1);
    hold_d     = (hold_q != 8'd0) ? hold_q - 8'd1 : hold_q;
    rr_d       = rr_q;
    stat_d     = stat_q;
    sel_d      = sel_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    din_d      = din_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    cfg_ack_d  = 1'b0;
    busy_d     = busy_q;
    wrote_d    = wrote_q;

    // Bus cycle setup: address/direction/data fixed for the whole E period.
    if (cyc_start) begin
      sel_d = 1'b1;
      unique case (state_q)
        INIT_MR: begin rs_d = 1'b0; rw_d = 1'b0; din_d = 8'h03; end
        INIT_CR: begin rs_d = 1'b0; rw_d = 1'b0; din_d = CR_INIT; end
        POLL:    begin rs_d = 1'b0; rw_d = 1'b1; end
        RD_DATA: begin rs_d = 1'b1; rw_d = 1'b1; end
        WR_CR:   begin rs_d = 1'b0; rw_d = 1'b0; din_d = bus.cfg_data; end
        WR_DATA: begin
          if (any_v) begin
            rs_d    = 1'b1;
            rw_d    = 1'b0;
            din_d   = gnt ? bus.tx1_data : bus.tx0_data;
            rr_d    = ~gnt;
            wrote_d = 1'b1;
          end else begin
            // Requester withdrew after the decision: fall back to a status read.
            rs_d    = 1'b0;
            rw_d    = 1'b1;
            wrote_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (cyc_end) begin
      unique case (state_q)
        INIT_MR: state_d = INIT_CR;
        INIT_CR: begin
          busy_d  = 1'b0;
          hold_d  = WR_HOLDOFF;
          state_d = POLL;
        end
        POLL: begin
          stat_d = bus.acia_dout;
          if (bus.acia_dout[0])
            state_d = RD_DATA;
          else if (bus.cfg_req)
            state_d = WR_CR;
          else if (bus.acia_dout[1] && hold_q == 8'd0 && any_v)
            state_d = WR_DATA;
        end
        RD_DATA: begin
          rx_data_d  = bus.acia_dout;
          rx_err_d   = stat_q[5:4];
          rx_valid_d = 1'b1;
          state_d    = POLL;
        end
        WR_CR: begin
          cfg_ack_d = 1'b1;
          hold_d    = WR_HOLDOFF;
          // A master-reset value leaves the ACIA unconfigured: redo the init write.
          if (din_q[1:0] == 2'b11) begin
            busy_d  = 1'b1;
            state_d = INIT_CR;
          end else begin
            state_d = POLL;
          end
        end
        WR_DATA: begin
          if (wrote_q) hold_d = WR_HOLDOFF;
          else         stat_d = bus.acia_dout;
          state_d = POLL;
        end
        default: state_d = INIT_MR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT_MR;
      ph_q       <= '0;
      hold_q     <= 8'd0;
      rr_q       <= 1'b0;
      stat_q     <= 8'd0;
      sel_q      <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      din_q      <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_err_q   <= 2'd0;
      cfg_ack_q  <= 1'b0;
      busy_q     <= 1'b1;
      wrote_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      hold_q     <= hold_d;
      rr_q       <= rr_d;
      stat_q     <= stat_d;
      sel_q      <= sel_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      din_q      <= din_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
      cfg_ack_q  <= cfg_ack_d;
      busy_q     <= busy_d;
      wrote_q    <= wrote_d;
    end
  end
endmodule

// File: tb/tb_acia_bus_sequencer.sv
// Directed bench for acia_bus_sequencer with a small behavioural ACIA register model.
module tb_acia_bus_sequencer;
  localparam int E_DIV = 32;
  localparam int HOLD  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  acia_bus_sequencer_if bus();

  acia_bus_sequencer #(.E_DIV(E_DIV), .CR_INIT(8'h16), .WR_HOLDOFF(8'd64)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ACIA model: base status plus an armed RX byte that a RDR read consumes.
  logic [7:0] base_stat = 8'h02;
  logic [7:0] rx_stat   = 8'h01;
  logic [7:0] rdr_v     = 8'h00;
  int rx_arm  = 0;
  int rx_took = 0;
  assign bus.acia_dout = bus.acia_rs ? rdr_v
                       : ((rx_arm != rx_took) ? (base_stat | rx_stat) : base_stat);

  // kinds: 1 CR write, 2 TDR write, 3 status read, 4 RDR read,
  //        5 rx_valid, 6 tx0_ready, 7 tx1_ready, 8 cfg_ack
  typedef struct {int kind; logic [7:0] d; logic [1:0] e; int t;} ev_t;
  ev_t  ev[$];
  logic e_prev = 1'b0;
  int   tcnt = 0;

  always @(negedge clk) begin
    tcnt++;
    if (bus.acia_e && !e_prev && bus.acia_sel) begin
      if (!bus.acia_rw) ev.push_back('{bus.acia_rs ? 2 : 1, bus.acia_din, 2'b00, tcnt});
      else begin
        ev.push_back('{bus.acia_rs ? 4 : 3, 8'h00, 2'b00, tcnt});
        if (bus.acia_rs && rx_arm != rx_took) rx_took++;
      end
    end
    e_prev = bus.acia_e;
    if (bus.rx_valid)  ev.push_back('{5, bus.rx_data, bus.rx_err, tcnt});
    if (bus.tx0_ready) ev.push_back('{6, bus.tx0_data, 2'b00, tcnt});
    if (bus.tx1_ready) ev.push_back('{7, bus.tx1_data, 2'b00, tcnt});
    if (bus.cfg_ack)   ev.push_back('{8, 8'h00, 2'b00, tcnt});
  end

  int n_chk = 0;
  int n_pass = 0;

  function automatic int count_kind(int from, int kind);
    int n = 0;
    for (int i = from; i < ev.size(); i++) if (ev[i].kind == kind) n++;
    return n;
  endfunction

  task automatic test_reset();
    bus.tx0_valid = 0; bus.tx1_valid = 0; bus.tx0_data = 0; bus.tx1_data = 0;
    bus.cfg_req = 0; bus.cfg_data = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.acia_e !== 1'b0) $display("FAIL reset_e got %b want 0", bus.acia_e); else n_pass++;
    n_chk++; if (bus.acia_sel !== 1'b0) $display("FAIL reset_sel got %b want 0", bus.acia_sel); else n_pass++;
    n_chk++; if (bus.busy_init !== 1'b1) $display("FAIL reset_busy got %b want 1", bus.busy_init); else n_pass++;
    n_chk++;
    if ({bus.rx_valid, bus.cfg_ack, bus.tx0_ready, bus.tx1_ready} !== 4'b0)
      $display("FAIL reset_pulses got %b want 0000", {bus.rx_valid, bus.cfg_ack, bus.tx0_ready, bus.tx1_ready});
    else n_pass++;
    n_chk++;
    if ({bus.rx_data, bus.rx_err, bus.acia_din} !== 18'd0)
      $display("FAIL reset_data got %h want 0", {bus.rx_data, bus.rx_err, bus.acia_din});
    else n_pass++;
  endtask

  task automatic test_init();
    int lg = ev.size();
    int k = 0;
    logic busy_mid = 1'b0;
    reset = 0;
    while (bus.busy_init && k < 200) begin
      @(negedge clk); k++;
      if (k == 40) busy_mid = bus.busy_init;
    end
    n_chk++; if (k !== 2*E_DIV) $display("FAIL init_busy_fall got %0d clk want %0d", k, 2*E_DIV); else n_pass++;
    n_chk++; if (busy_mid !== 1'b1) $display("FAIL init_busy_mid got %b want 1", busy_mid); else n_pass++;
    n_chk++;
    if (ev.size() < lg+2 || ev[lg].kind != 1 || ev[lg].d !== 8'h03 || ev[lg+1].kind != 1 || ev[lg+1].d !== 8'h16)
      $display("FAIL init_cr_writes got size %0d want CR 03 then CR 16", ev.size() - lg);
    else n_pass++;
    repeat (3*E_DIV) @(negedge clk);
    n_chk++;
    if (count_kind(lg, 3) !== 3 || count_kind(lg, 1) !== 2)
      $display("FAIL init_polls got %0d status reads want 3", count_kind(lg, 3));
    else n_pass++;
  endtask

  task automatic rx_one(input logic [7:0] st, input logic [7:0] d, input logic [1:0] err, input string nm);
    int lg = ev.size();
    int k = 0;
    int idx = -1;
    base_stat = 8'h00; rx_stat = st; rdr_v = d; rx_arm++;
    while (!bus.rx_valid && k < 400) begin @(negedge clk); k++; end
    n_chk++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== d || bus.rx_err !== err)
      $display("FAIL %s got v=%b d=%h e=%b want v=1 d=%h e=%b", nm, bus.rx_valid, bus.rx_data, bus.rx_err, d, err);
    else n_pass++;
    repeat (3*E_DIV) @(negedge clk);
    n_chk++; if (count_kind(lg, 5) !== 1) $display("FAIL %s_once got %0d pulses want 1", nm, count_kind(lg, 5)); else n_pass++;
    for (int i = lg; i < ev.size(); i++) if (ev[i].kind == 5 && idx < 0) idx = i;
    n_chk++;
    if (idx < lg+1 || ev[idx-1].kind != 4)
      $display("FAIL %s_rdr_read got prior kind %0d want 4", nm, (idx > lg) ? ev[idx-1].kind : -1);
    else n_pass++;
    base_stat = 8'h02;
  endtask

  task automatic test_rx();
    rx_one(8'h01, 8'hA5, 2'b00, "rx_plain");
    rx_one(8'h31, 8'h3C, 2'b11, "rx_err");
  endtask

  task automatic test_tx_rr();
    int lg = ev.size();
    int n = 0;
    logic [7:0] got [$];
    int tt [$];
    int mingap = 1000000;
    bus.tx0_data = 8'h11; bus.tx1_data = 8'h22; bus.tx0_valid = 1; bus.tx1_valid = 1;
    for (int i = 0; i < 3000 && n < 4; i++) begin
      @(negedge clk);
      if (bus.tx0_ready || bus.tx1_ready) begin
        n++;
        if (n == 4) begin @(posedge clk); #1; bus.tx0_valid = 0; bus.tx1_valid = 0; end
      end
    end
    n_chk++; if (n !== 4) $display("FAIL tx_ready_count got %0d want 4", n); else n_pass++;
    repeat (6*E_DIV) @(negedge clk);
    for (int i = lg; i < ev.size(); i++) if (ev[i].kind == 2) begin got.push_back(ev[i].d); tt.push_back(ev[i].t); end
    n_chk++;
    if (got.size() != 4 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h11 || got[3] !== 8'h22)
      $display("FAIL tx_rr_order got %0d writes want 11,22,11,22", got.size());
    else n_pass++;
    n_chk++;
    if (count_kind(lg, 6) !== 2 || count_kind(lg, 7) !== 2)
      $display("FAIL tx_ready_split got %0d/%0d want 2/2", count_kind(lg, 6), count_kind(lg, 7));
    else n_pass++;
    for (int i = 1; i < tt.size(); i++) if (tt[i] - tt[i-1] < mingap) mingap = tt[i] - tt[i-1];
    n_chk++; if (mingap < HOLD) $display("FAIL tx_holdoff_gap got %0d want >=%0d", mingap, HOLD); else n_pass++;
  endtask

  task automatic test_priority();
    int lg = ev.size();
    logic ack_seen = 0, rdy_seen = 0;
    int ord [$];
    int cr_i = -1, tdr_i = -1;
    rdr_v = 8'h5A; rx_stat = 8'h01; rx_arm++;
    bus.tx0_data = 8'h33; bus.tx0_valid = 1;
    bus.cfg_data = 8'h15; bus.cfg_req = 1;
    for (int i = 0; i < 3000 && !(ack_seen && rdy_seen); i++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin ack_seen = 1; bus.cfg_req = 0; end
      if (bus.tx0_ready) begin rdy_seen = 1; @(posedge clk); #1; bus.tx0_valid = 0; end
    end
    repeat (2*E_DIV) @(negedge clk);
    for (int i = lg; i < ev.size(); i++) begin
      if (ev[i].kind == 5 || ev[i].kind == 6 || ev[i].kind == 8) ord.push_back(ev[i].kind);
      if (ev[i].kind == 1 && ev[i].d == 8'h15 && cr_i < 0) cr_i = i;
      if (ev[i].kind == 2 && ev[i].d == 8'h33 && tdr_i < 0) tdr_i = i;
    end
    n_chk++;
    if (ord.size() != 3 || ord[0] != 5 || ord[1] != 8 || ord[2] != 6)
      $display("FAIL prio_order got %0d events want rx,cfg,tx", ord.size());
    else n_pass++;
    n_chk++;
    if (cr_i < 0 || tdr_i < 0 || cr_i > tdr_i)
      $display("FAIL prio_bus got cr@%0d tdr@%0d want CR 15 before TDR 33", cr_i, tdr_i);
    else n_pass++;
  endtask

  task automatic test_cfg_mr();
    int lg = ev.size();
    int k = 0;
    logic [7:0] crs [$];
    n_chk++; if (bus.busy_init !== 1'b0) $display("FAIL cfg_busy_pre got %b want 0", bus.busy_init); else n_pass++;
    bus.cfg_data = 8'h03; bus.cfg_req = 1;
    while (!bus.cfg_ack && k < 400) begin @(negedge clk); k++; end
    n_chk++;
    if (bus.cfg_ack !== 1'b1 || bus.busy_init !== 1'b1)
      $display("FAIL cfg_ack_busy got ack=%b busy=%b want 1 1", bus.cfg_ack, bus.busy_init);
    else n_pass++;
    bus.cfg_req = 0;
    k = 0;
    while (bus.busy_init && k < 300) begin @(negedge clk); k++; end
    n_chk++; if (k !== E_DIV) $display("FAIL cfg_reinit_len got %0d clk want %0d", k, E_DIV); else n_pass++;
    for (int i = lg; i < ev.size(); i++) if (ev[i].kind == 1) crs.push_back(ev[i].d);
    n_chk++;
    if (crs.size() != 2 || crs[0] !== 8'h03 || crs[1] !== 8'h16)
      $display("FAIL cfg_cr_seq got %0d CR writes want 03 then 16", crs.size());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int k = 0;
    int lg;
    repeat (3*E_DIV) @(negedge clk);
    bus.tx0_data = 8'h77; bus.tx0_valid = 1;
    while (!bus.tx0_ready && k < 1000) begin @(negedge clk); k++; end
    n_chk++; if (bus.tx0_ready !== 1'b1) $display("FAIL abort_grant got %b want 1", bus.tx0_ready); else n_pass++;
    @(posedge clk); #1; bus.tx0_valid = 0;
    repeat (E_DIV/2) @(posedge clk);
    #1;
    n_chk++;
    if (bus.acia_e !== 1'b1 || bus.acia_sel !== 1'b1)
      $display("FAIL abort_mid got e=%b sel=%b want 1 1", bus.acia_e, bus.acia_sel);
    else n_pass++;
    reset = 1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.acia_e !== 1'b0 || bus.acia_sel !== 1'b0)
      $display("FAIL abort_bus got e=%b sel=%b want 0 0", bus.acia_e, bus.acia_sel);
    else n_pass++;
    @(negedge clk);
    lg = ev.size();
    reset = 0;
    k = 0;
    while (bus.busy_init && k < 300) begin @(negedge clk); k++; end
    repeat (4*E_DIV) @(negedge clk);
    n_chk++;
    if (ev.size() < lg+2 || ev[lg].kind != 1 || ev[lg].d !== 8'h03 || ev[lg+1].kind != 1 || ev[lg+1].d !== 8'h16)
      $display("FAIL abort_restart got size %0d want CR 03 then CR 16", ev.size() - lg);
    else n_pass++;
    n_chk++;
    if (count_kind(lg, 6) + count_kind(lg, 7) !== 0 || count_kind(lg, 2) !== 0)
      $display("FAIL abort_no_repeat got %0d ready %0d tdr want 0 0",
               count_kind(lg, 6) + count_kind(lg, 7), count_kind(lg, 2));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_rx();
    test_tx_rr();
    test_priority();
    test_cfg_mr();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
